// File: rtl/clfsr_keystream_gen.sv
// -----------------------------------------------------------------------------
// clfsr_keystream_gen
//
// Keystream source for the C-LFSR image encryptor. A Q0.16 logistic map
// (x' = r*x*(1-x)) is warmed up after start and then periodically folded into
// a 32-bit Galois LFSR. The LFSR emits one 24-bit key word per pixel over a
// valid/ready handshake; the encrypt stage XORs word i into pixel i.
//
// Handshake: key_data is presented with key_valid; a word is consumed on every
// rising clock edge where key_valid && key_ready are both high. While key_valid
// is high and key_ready is low, key_data and words_out are held unchanged.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous reset, active-low
//   start      in   1    one-cycle pulse; latches seeds and starts an image (ignored while busy)
//   seed_x     in   16   initial logistic state
//   seed_lfsr  in   32   initial LFSR state
//   key_ready  in   1    consumer accepts key_data this cycle
//   key_valid  out  1    key_data valid
//   key_data   out  24   key word = lfsr[23:0] ({R,G,B} key bytes)
//   busy       out  1    high in every state except IDLE
//   done       out  1    one-cycle pulse after the last word of an image is accepted
//   words_out  out  17   accepted-word count for the current image
//   dbg_state  out  3    current FSM state (debug observation only)
// -----------------------------------------------------------------------------
module clfsr_keystream_gen #(
    parameter int                 FRAC_W        = 16,
    parameter logic [FRAC_W+1:0]  R_COEF        = 18'h3FD70,
    parameter int                 WARMUP_ITERS  = 64,
    parameter int                 RESEED_PERIOD = 256,
    parameter int                 NUM_WORDS     = 65536,
    parameter logic [31:0]        LFSR_TAPS     = 32'h80200003
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FRAC_W-1:0] seed_x,
    input  logic [31:0]       seed_lfsr,
    input  logic              key_ready,
    output logic              key_valid,
    output logic [23:0]       key_data,
    output logic              busy,
    output logic              done,
    output logic [16:0]       words_out,
    output logic [2:0]        dbg_state
);

    // Counter widths and terminal values. Counters compare against "last"
    // so the +1 never needs an extra bit.
    localparam int ITER_W   = (WARMUP_ITERS  > 1) ? $clog2(WARMUP_ITERS)  : 1;
    localparam int RESEED_W = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD) : 1;
    localparam logic [ITER_W-1:0]   ITER_LAST   = ITER_W'(WARMUP_ITERS - 1);
    localparam logic [RESEED_W-1:0] RESEED_LAST = RESEED_W'(RESEED_PERIOD - 1);
    localparam logic [16:0]         WORDS_LAST  = 17'(NUM_WORDS - 1);

    localparam logic [FRAC_W-1:0] X_SEED_DEFAULT = 16'h8000;
    localparam logic [FRAC_W-1:0] X_ZERO_ESCAPE  = 16'h5A5A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHAOS_A = 3'd1,
        ST_CHAOS_B = 3'd2,
        ST_MIX     = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    state_t                state_q,       state_d;
    logic [FRAC_W-1:0]     x_q,           x_d;
    logic [FRAC_W-1:0]     t_q,           t_d;
    logic [31:0]           lfsr_q,        lfsr_d;
    logic [ITER_W-1:0]     iter_cnt_q,    iter_cnt_d;
    logic [RESEED_W-1:0]   reseed_cnt_q,  reseed_cnt_d;
    logic                  reseed_mode_q, reseed_mode_d;
    logic [16:0]           words_q,       words_d;
    logic                  key_valid_q,   key_valid_d;
    logic [23:0]           key_data_q,    key_data_d;
    logic                  done_q,        done_d;

    // ---------------------------------------------------------------------
    // Logistic map datapath (unsigned, truncating)
    // ---------------------------------------------------------------------
    // Stage A: t = x*(1-x) in Q0.16. (1-x) needs 17 bits because x may be 0.
    logic [FRAC_W:0]     one_minus_x;
    logic [2*FRAC_W:0]   prod_a;
    // Stage B: p = r*t, r in Q2.16, so p carries two integer bits.
    logic [2*FRAC_W+1:0] prod_b;
    logic [FRAC_W+1:0]   p_val;
    logic [FRAC_W-1:0]   x_sat;
    logic [FRAC_W-1:0]   x_next;

    assign one_minus_x = {1'b1, {FRAC_W{1'b0}}} - {1'b0, x_q};
    assign prod_a      = {{(FRAC_W+1){1'b0}}, x_q} * {{FRAC_W{1'b0}}, one_minus_x};
    assign prod_b      = {{FRAC_W{1'b0}}, R_COEF} * {{(FRAC_W+2){1'b0}}, t_q};
    assign p_val       = prod_b[2*FRAC_W+1:FRAC_W];
    assign x_sat       = (p_val[FRAC_W+1:FRAC_W] != 2'b00) ? {FRAC_W{1'b1}} : p_val[FRAC_W-1:0];
    // A zero state is a fixed point of the map; kick it out to a known value.
    assign x_next      = (x_sat == '0) ? X_ZERO_ESCAPE : x_sat;

    // Fraction bits of both products are discarded; the integer bit of
    // prod_a can never be set because x*(1-x) <= 1/4.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_a[FRAC_W-1:0], prod_a[2*FRAC_W], prod_b[FRAC_W-1:0]};

    // ---------------------------------------------------------------------
    // LFSR datapath
    // ---------------------------------------------------------------------
    logic [31:0] lfsr_step;
    logic [31:0] lfsr_mix;
    logic [31:0] lfsr_mixed;

    assign lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    assign lfsr_mix   = lfsr_q ^ {x_q, ~x_q};
    // The all-zero state would lock the LFSR forever.
    assign lfsr_mixed = (lfsr_mix == 32'd0) ? 32'd1 : lfsr_mix;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            t_q           <= '0;
            lfsr_q        <= '0;
            iter_cnt_q    <= '0;
            reseed_cnt_q  <= '0;
            reseed_mode_q <= 1'b0;
            words_q       <= '0;
            key_valid_q   <= 1'b0;
            key_data_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            t_q           <= t_d;
            lfsr_q        <= lfsr_d;
            iter_cnt_q    <= iter_cnt_d;
            reseed_cnt_q  <= reseed_cnt_d;
            reseed_mode_q <= reseed_mode_d;
            words_q       <= words_d;
            key_valid_q   <= key_valid_d;
            key_data_q    <= key_data_d;
            done_q        <= done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        t_d           = t_q;
        lfsr_d        = lfsr_q;
        iter_cnt_d    = iter_cnt_q;
        reseed_cnt_d  = reseed_cnt_q;
        reseed_mode_d = reseed_mode_q;
        words_d       = words_q;
        key_valid_d   = key_valid_q;
        key_data_d    = key_data_q;
        done_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d           = (seed_x == '0) ? X_SEED_DEFAULT : seed_x;
                    lfsr_d        = (seed_lfsr == 32'd0) ? 32'd1 : seed_lfsr;
                    iter_cnt_d    = '0;
                    words_d       = '0;
                    reseed_mode_d = 1'b0;
                    state_d       = ST_CHAOS_A;
                end
            end

            ST_CHAOS_A: begin
                t_d     = prod_a[2*FRAC_W-1:FRAC_W];
                state_d = ST_CHAOS_B;
            end

            ST_CHAOS_B: begin
                x_d = x_next;
                if (reseed_mode_q) begin
                    state_d = ST_MIX;
                end else begin
                    iter_cnt_d = iter_cnt_q + 1'b1;
                    state_d    = (iter_cnt_q == ITER_LAST) ? ST_MIX : ST_CHAOS_A;
                end
            end

            ST_MIX: begin
                lfsr_d       = lfsr_mixed;
                reseed_cnt_d = '0;
                key_valid_d  = 1'b1;
                key_data_d   = lfsr_mixed[23:0];
                state_d      = ST_RUN;
            end

            ST_RUN: begin
                if (key_valid_q && key_ready) begin
                    lfsr_d       = lfsr_step;
                    words_d      = words_q + 17'd1;
                    reseed_cnt_d = reseed_cnt_q + 1'b1;
                    // End of image wins over a reseed landing on the same word.
                    if (words_q == WORDS_LAST) begin
                        done_d      = 1'b1;
                        key_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (reseed_cnt_q == RESEED_LAST) begin
                        key_valid_d   = 1'b0;
                        reseed_mode_d = 1'b1;
                        state_d       = ST_CHAOS_A;
                    end else begin
                        key_data_d = lfsr_step[23:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign key_valid = key_valid_q;
    assign key_data  = key_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign words_out = words_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_clfsr_keystream_gen.sv
// -----------------------------------------------------------------------------
// tb_clfsr_keystream_gen
//
// Drives images through the keystream generator with a small configuration
// (WARMUP_ITERS=1, RESEED_PERIOD=4, NUM_WORDS=8). A reference model computes
// each image's key words from the seeds with plain arithmetic and pushes them
// into exp_q when a start is issued; a negedge monitor pops and compares on
// every handshake and also watches holds, gaps, done and words_out.
// -----------------------------------------------------------------------------
module tb_clfsr_keystream_gen;

    localparam int          WARMUP  = 1;
    localparam int          PERIOD  = 4;
    localparam int          NW      = 8;
    localparam longint      R_VAL   = 'h3FD70;
    localparam logic [31:0] TAPS    = 32'h80200003;
    localparam int          LIMIT   = 500;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] seed_x;
    logic [31:0] seed_lfsr;
    logic        key_ready;
    logic        key_valid;
    logic [23:0] key_data;
    logic        busy;
    logic        done;
    logic [16:0] words_out;
    logic [2:0]  dbg_state;

    clfsr_keystream_gen #(
        .WARMUP_ITERS  (WARMUP),
        .RESEED_PERIOD (PERIOD),
        .NUM_WORDS     (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed_x    (seed_x),
        .seed_lfsr (seed_lfsr),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_data  (key_data),
        .busy      (busy),
        .done      (done),
        .words_out (words_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_q[$];
    logic [23:0] got_words[NW];
    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    int hold_left = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_logistic(input logic [15:0] x);
        longint t;
        longint p;
        t = (longint'(x) * (65536 - longint'(x))) / 65536;
        p = (R_VAL * t) / 65536;
        if (p > 65535) p = 65535;
        if (p == 0) return 16'h5A5A;
        return 16'(p);
    endfunction

    function automatic logic [31:0] model_mix(input logic [31:0] l, input logic [15:0] x);
        logic [31:0] v;
        v = l ^ {x, ~x};
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // One Galois shift: divide by x, reduce by the tap polynomial on carry-out.
    function automatic logic [31:0] model_next(input logic [31:0] l);
        logic [31:0] v;
        v = l >> 1;
        if (l[0]) v = v ^ TAPS;
        return v;
    endfunction

    task automatic push_image(input logic [15:0] sx, input logic [31:0] sl);
        logic [15:0] x;
        logic [31:0] l;
        x = (sx == 16'd0) ? 16'h8000 : sx;
        l = (sl == 32'd0) ? 32'd1 : sl;
        for (int i = 0; i < WARMUP; i++) x = model_logistic(x);
        l = model_mix(l, x);
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(l[23:0]);
            l = model_next(l);
            if ((i + 1) < NW && ((i + 1) % PERIOD) == 0) begin
                x = model_logistic(x);
                l = model_mix(l, x);
            end
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        key_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_left > 0) begin
                key_ready = 1'b0;
                hold_left--;
            end else if (rand_ready) begin
                key_ready = ($urandom_range(0, 3) != 0);
            end else begin
                key_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          seen_valid = 1'b0;
    int          gap        = 0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_data  = '0;
    logic [16:0] prev_words = '0;
    bit          prev_done  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen_valid = 1'b0;
            gap        = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (key_valid && !busy) check("valid_without_busy", 32'(busy), 32'd1);

            if (prev_stall) begin
                check("hold_valid", 32'(key_valid), 32'd1);
                check("hold_data",  32'(key_data),  32'(prev_data));
                check("hold_words", 32'(words_out), 32'(prev_words));
            end

            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(key_data), 32'hFFFFFFFF);
                end else begin
                    check("words_out", 32'(words_out), 32'(NW - exp_q.size()));
                    if (words_out < 17'(NW)) got_words[words_out[2:0]] = key_data;
                    check("key_data", 32'(key_data), 32'(exp_q.pop_front()));
                end
            end

            if (done) begin
                done_cnt++;
                check("done_single_pulse", 32'(prev_done), 32'd0);
                check("done_words_out",    32'(words_out), 32'(NW));
                check("done_busy",         32'(busy),      32'd0);
                check("done_queue_empty",  32'(exp_q.size()), 32'd0);
            end

            if (!busy) begin
                seen_valid = 1'b0;
                gap        = 0;
            end else if (!key_valid) begin
                gap++;
            end else begin
                if (gap != 0) begin
                    if (seen_valid) check("reseed_gap", 32'(gap), 32'd3);
                    else            check("start_latency", 32'(gap), 32'(2 * WARMUP + 1));
                end
                gap        = 0;
                seen_valid = 1'b1;
            end

            prev_stall = key_valid && !key_ready;
            prev_data  = key_data;
            prev_words = words_out;
            prev_done  = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_words(input int target);
        int n;
        n = 0;
        while (int'(words_out) < target && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (int'(words_out) < target) check("wait_words_timeout", 32'(words_out), 32'(target));
    endtask

    task automatic start_image(input logic [15:0] sx, input logic [31:0] sl);
        wait_idle();
        @(posedge clk);
        #1;
        push_image(sx, sl);
        exp_done++;
        start     = 1'b1;
        seed_x    = sx;
        seed_lfsr = sl;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_key_data"},  32'(key_data),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_words_out"}, 32'(words_out), 32'd0);
        check({tag, "_state"},     32'(dbg_state), 32'd0);
    endtask

    task automatic check_t1_words(input string tag);
        check({tag, "_word0"}, 32'(got_words[0]), 32'h6856DB);
        check({tag, "_word1"}, 32'(got_words[1]), 32'h942B6E);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        seed_x    = '0;
        seed_lfsr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Known-answer image with ready always high.
        rand_ready = 1'b0;
        start_image(16'h8000, 32'h12345678);
        wait_idle();
        check_t1_words("t1");

        // Zero seeds fall back to 0x8000 / 1.
        start_image(16'h0000, 32'h00000000);
        wait_idle();

        // Consumer stalls across the first valid word.
        hold_left = 8;
        start_image(16'h8000, 32'h12345678);
        wait_idle();
        check_t1_words("t3");

        // A start while busy must not disturb the running image.
        start_image(16'h1234, 32'hCAFEF00D);
        wait_words(2);
        start     = 1'b1;
        seed_x    = 16'hFFFF;
        seed_lfsr = 32'h0BADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset in the middle of RUN, then repeat the known-answer image.
        start_image(16'h8000, 32'h12345678);
        wait_words(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        exp_done--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_image(16'h8000, 32'h12345678);
        wait_idle();
        check_t1_words("t5");

        // Random seeds and random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] sx;
            logic [31:0] sl;
            sx = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            sl = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            start_image(sx, sl);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        check("done_count",  32'(done_cnt),     32'(exp_done));
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so the run always ends even if the design wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x1 expected 0x0");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
